// File: rtl/subword_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : subword_mem_ctrl_pkg
// Purpose  : Shared encodings for the sub-word memory controller: access
//            sizes, response error codes, FSM states and the request check.
// Revision : 1.0 - initial release
// ============================================================================
package subword_mem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_SIZE     = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RD   = 2'd1;
    localparam state_t ST_WR   = 2'd2;
    localparam state_t ST_RESP = 2'd3;

    // Illegal size outranks misalignment; bytes can never be misaligned.
    function automatic logic [1:0] check_request(input logic [1:0] size,
                                                 input logic [1:0] addr_lo);
        logic [1:0] err;
        err = ERR_OK;
        if (size == SZ_ILLEGAL)
            err = ERR_SIZE;
        else if (size == SZ_HALF && addr_lo[0])
            err = ERR_MISALIGN;
        else if (size == SZ_WORD && addr_lo != 2'b00)
            err = ERR_MISALIGN;
        return err;
    endfunction

endpackage
`default_nettype wire

// File: rtl/subword_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : subword_mem_ctrl_if / subword_mem_bus_if
// Purpose  : Execute-stage request/response bus and word-addressed memory bus.
//            mem_be exists only when SUBWORD_MEM_BE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface subword_mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic [1:0]        resp_err;

    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface subword_mem_bus_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;
`ifdef SUBWORD_MEM_BE_EN
    logic [3:0]        mem_be;
`endif

    modport master (
`ifdef SUBWORD_MEM_BE_EN
        output mem_be,
`endif
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
`ifdef SUBWORD_MEM_BE_EN
        input  mem_be,
`endif
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface
`default_nettype wire

// File: rtl/subword_lane_unit.sv
`default_nettype none
// ============================================================================
// Module   : subword_lane_unit
// Purpose  : Combinational lane logic: load extraction with sign/zero
//            extension, store lane enables, and either the RMW merge or the
//            replicated store data (SUBWORD_MEM_BE_EN).
// Revision : 1.0 - initial release
// ============================================================================
module subword_lane_unit
    import subword_mem_ctrl_pkg::*;
(
    input  wire logic [1:0]  size,
    input  wire logic [1:0]  lane,
    input  wire logic        is_unsigned,
    input  wire logic [31:0] rdata,
    input  wire logic [31:0] wdata,
    output logic [31:0]      load_data,
`ifdef SUBWORD_MEM_BE_EN
    output logic [31:0]      wdata_repl,
    output logic [3:0]       lane_be
`else
    output logic [31:0]      merge_data
`endif
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_repl;
    logic [3:0]  w_be;
    logic [31:0] w_merge;

    always_comb begin
        w_byte = 8'(rdata >> {lane, 3'b000});
        w_half = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: load_data = {{16{~is_unsigned & w_half[15]}}, w_half};
            default: load_data = rdata;
        endcase
    end

    always_comb begin
        case (size)
            SZ_BYTE: begin
                w_repl = {4{wdata[7:0]}};
                w_be   = 4'b0001 << lane;
            end
            SZ_HALF: begin
                w_repl = {2{wdata[15:0]}};
                w_be   = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_repl = wdata;
                w_be   = 4'b1111;
            end
        endcase
    end

    // Replicated data under the lane mask is exactly the store lanes in place.
    always_comb begin
        w_merge = rdata;
        for (int i = 0; i < 4; i++) begin
            if (w_be[i])
                w_merge[8*i +: 8] = w_repl[8*i +: 8];
        end
    end

`ifdef SUBWORD_MEM_BE_EN
    assign wdata_repl = w_repl;
    assign lane_be    = w_be;
`else
    assign merge_data = w_merge;
`endif

endmodule
`default_nettype wire

// File: rtl/subword_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : subword_mem_ctrl
// Purpose  : Byte/half/word load-store sequencer for a word-addressed memory;
//            RMW sub-word stores, or byte-enabled writes with SUBWORD_MEM_BE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module subword_mem_ctrl
    import subword_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    subword_mem_ctrl_if.slave cpu,
    subword_mem_bus_if.master mem
);

    localparam int c_cnt_w = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last =
        c_cnt_w'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t              r_state;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic [1:0]          r_err;
    logic [c_cnt_w-1:0]  r_cnt;
`ifndef SUBWORD_MEM_BE_EN
    logic                r_store;
`endif

    logic        w_accept;
    logic [1:0]  w_req_err;
    logic        w_timeout;
    logic [31:0] w_load_data;
`ifdef SUBWORD_MEM_BE_EN
    logic [31:0] w_wdata_repl;
    logic [3:0]  w_lane_be;
`else
    logic [31:0] w_merge_data;
`endif

    assign w_accept  = cpu.req_valid && (r_state == ST_IDLE);
    assign w_req_err = check_request(cpu.req_size, cpu.req_addr[1:0]);
    // Fires on the last waiting cycle so mem_req is high exactly TIMEOUT_CYCLES cycles.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == c_cnt_last);

    subword_lane_unit u_lane (
        .size        (r_size),
        .lane        (r_addr[1:0]),
        .is_unsigned (r_unsigned),
        .rdata       (mem.mem_rdata),
        .wdata       (r_wdata),
        .load_data   (w_load_data),
`ifdef SUBWORD_MEM_BE_EN
        .wdata_repl  (w_wdata_repl),
        .lane_be     (w_lane_be)
`else
        .merge_data  (w_merge_data)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_rdata    <= 32'h0;
            r_err      <= ERR_OK;
            r_cnt      <= '0;
`ifndef SUBWORD_MEM_BE_EN
            r_store    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_size     <= cpu.req_size;
                        r_unsigned <= cpu.req_unsigned;
                        r_addr     <= cpu.req_addr;
                        r_wdata    <= cpu.req_wdata;
                        r_cnt      <= '0;
`ifndef SUBWORD_MEM_BE_EN
                        r_store    <= cpu.req_store;
`endif
                        if (w_req_err != ERR_OK) begin
                            r_err   <= w_req_err;
                            r_state <= ST_RESP;
                        end else if (!cpu.req_store)
                            r_state <= ST_RD;
`ifdef SUBWORD_MEM_BE_EN
                        else
                            r_state <= ST_WR;
`else
                        else if (cpu.req_size == SZ_WORD)
                            r_state <= ST_WR;
                        else
                            r_state <= ST_RD;
`endif
                    end
                end
                ST_RD: begin
                    if (mem.mem_ack) begin
                        r_cnt <= '0;
`ifndef SUBWORD_MEM_BE_EN
                        if (r_store) begin
                            r_wdata <= w_merge_data;
                            r_state <= ST_WR;
                        end else
`endif
                        begin
                            r_rdata <= w_load_data;
                            r_state <= ST_RESP;
                        end
                    end else if (w_timeout) begin
                        r_err   <= ERR_TIMEOUT;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WR: begin
                    if (mem.mem_ack) begin
                        r_state <= ST_RESP;
                    end else if (w_timeout) begin
                        r_err   <= ERR_TIMEOUT;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_rdata <= 32'h0;
                    r_err   <= ERR_OK;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cpu.req_ready  = (r_state == ST_IDLE);
    assign cpu.resp_valid = (r_state == ST_RESP);
    assign cpu.resp_rdata = r_rdata;
    assign cpu.resp_err   = r_err;

    assign mem.mem_req  = (r_state == ST_RD) || (r_state == ST_WR);
    assign mem.mem_we   = (r_state == ST_WR);
    assign mem.mem_addr = {r_addr[ADDR_W-1:2], 2'b00};
`ifdef SUBWORD_MEM_BE_EN
    assign mem.mem_wdata = (r_state == ST_WR) ? w_wdata_repl : 32'h0;
    assign mem.mem_be    = (r_state == ST_WR) ? w_lane_be : 4'b0000;
`else
    assign mem.mem_wdata = (r_state == ST_WR) ? r_wdata : 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_subword_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_subword_mem_ctrl
// Purpose  : Self-checking bench: directed and random loads/stores against a
//            behavioural memory and reference model (TIMEOUT_CYCLES = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_subword_mem_ctrl;
    import subword_mem_ctrl_pkg::*;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    subword_mem_ctrl_if #(.ADDR_W(32)) cpu ();
    subword_mem_bus_if  #(.ADDR_W(32)) mbus ();

    subword_mem_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cpu   (cpu),
        .mem   (mbus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] mem_arr [0:255];
    logic [31:0] ref_mem [0:255];
    int  ack_delay = 0;
    bit  no_ack    = 1'b0;
    int  waited    = 0;
    int  rd_cnt, wr_cnt, req_cycles, we_cycles;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_be;

    // Memory responder: decides at the falling edge what the DUT sees next rising edge.
    always @(negedge clk) begin
        if (mbus.mem_req) begin
            req_cycles++;
            if (mbus.mem_we) we_cycles++;
            if (!no_ack && waited >= ack_delay) begin
                mbus.mem_ack = 1'b1;
                waited       = 0;
                last_addr    = mbus.mem_addr;
                if (mbus.mem_we) begin
                    wr_cnt++;
                    last_wdata = mbus.mem_wdata;
`ifdef SUBWORD_MEM_BE_EN
                    last_be = mbus.mem_be;
                    for (int b = 0; b < 4; b++)
                        if (mbus.mem_be[b])
                            mem_arr[mbus.mem_addr[9:2]][8*b +: 8] = mbus.mem_wdata[8*b +: 8];
`else
                    mem_arr[mbus.mem_addr[9:2]] = mbus.mem_wdata;
`endif
                    mbus.mem_rdata = $urandom;
                end else begin
                    rd_cnt++;
                    mbus.mem_rdata = mem_arr[mbus.mem_addr[9:2]];
                end
            end else begin
                mbus.mem_ack   = 1'b0;
                mbus.mem_rdata = $urandom;
                waited++;
            end
        end else begin
            mbus.mem_ack   = 1'b0;
            mbus.mem_rdata = $urandom;
            waited         = 0;
        end
    end

    function automatic logic [1:0] model_err(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 2'b11;
        if (sz == 2'b01 && (a % 2) != 0) return 2'b01;
        if (sz == 2'b10 && (a % 4) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                               input bit uns, input logic [31:0] a);
        logic [31:0] v;
        case (sz)
            2'b00: begin
                v = (word >> (8 * (a % 4))) & 32'hFF;
                if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
            end
            2'b01: begin
                v = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
                if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [31:0] wd, input logic [31:0] a);
        logic [31:0] mask;
        int sh;
        case (sz)
            2'b00:   begin sh = 8 * (a % 4);         mask = 32'hFF << sh;   end
            2'b01:   begin sh = 16 * ((a / 2) % 2);  mask = 32'hFFFF << sh; end
            default: begin sh = 0;                   mask = 32'hFFFF_FFFF;  end
        endcase
        return (word & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic do_req(input bit hold, input bit st, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic [1:0] err, output int lat);
        int n;
        rd_cnt = 0; wr_cnt = 0; req_cycles = 0; we_cycles = 0;
        last_addr = 32'hFFFF_FFFF; last_wdata = 32'h0; last_be = 4'h0;
        if (!hold) @(negedge clk);
        cpu.req_valid = 1'b1; cpu.req_store = st; cpu.req_size = sz;
        cpu.req_unsigned = uns; cpu.req_addr = a; cpu.req_wdata = wd;
        n = 0;
        while (!cpu.req_ready && n < 20) begin @(negedge clk); n++; end
        tests_run++;
        if (cpu.req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL accept: req_ready=%b required 1", cpu.req_ready);
        end
        @(posedge clk); #1;
        cpu.req_valid = 1'b0; cpu.req_store = $urandom; cpu.req_size = $urandom;
        cpu.req_unsigned = $urandom; cpu.req_addr = $urandom; cpu.req_wdata = $urandom;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!cpu.resp_valid && lat < 60);
        rdata = cpu.resp_rdata;
        err   = cpu.resp_err;
        tests_run++;
        if (cpu.resp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL resp_wait: resp_valid=%b required 1 within 60 cycles", cpu.resp_valid);
        end
        tests_run++;
        if (cpu.req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_in_resp: req_ready=%b required 0", cpu.req_ready);
        end
    endtask

    logic [31:0] g_rdata;
    logic [1:0]  g_err;
    int          g_lat;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (cpu.req_ready !== 1'b1 || cpu.resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_handshake: ready=%b valid=%b required 1/0", cpu.req_ready, cpu.resp_valid);
        end
        tests_run++;
        if (cpu.resp_rdata !== 32'h0 || cpu.resp_err !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_resp: rdata=%h err=%b required 0/0", cpu.resp_rdata, cpu.resp_err);
        end
        tests_run++;
        if (mbus.mem_req !== 1'b0 || mbus.mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mem_ctl: req=%b we=%b required 0/0", mbus.mem_req, mbus.mem_we);
        end
        tests_run++;
        if (mbus.mem_addr !== 32'h0 || mbus.mem_wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mem_data: addr=%h wdata=%h required 0/0", mbus.mem_addr, mbus.mem_wdata);
        end
`ifdef SUBWORD_MEM_BE_EN
        tests_run++;
        if (mbus.mem_be !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_be: mem_be=%b required 0000", mbus.mem_be);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (cpu.req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_ready: req_ready=%b required 1", cpu.req_ready);
        end
    endtask

    task automatic test_loads();
        ack_delay = 0;
        mem_arr[8'h40] = 32'h80AA_BBCC; ref_mem[8'h40] = 32'h80AA_BBCC;
        do_req(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h103, 32'h0, g_rdata, g_err, g_lat);
        tests_run++;
        if (g_rdata !== 32'hFFFF_FF80 || g_err !== 2'b00) begin
            tests_failed++;
            $display("FAIL lb: rdata=%h err=%b required ffffff80/00", g_rdata, g_err);
        end
        tests_run++;
        if (g_lat != 2) begin
            tests_failed++;
            $display("FAIL lb_latency: %0d cycles required 2", g_lat);
        end
        mem_arr[8'h40] = 32'h8001_FFFF; ref_mem[8'h40] = 32'h8001_FFFF;
        do_req(1'b0, 1'b0, SZ_HALF, 1'b1, 32'h102, 32'h0, g_rdata, g_err, g_lat);
        tests_run++;
        if (g_rdata !== 32'h0000_8001 || g_err !== 2'b00) begin
            tests_failed++;
            $display("FAIL lhu: rdata=%h err=%b required 00008001/00", g_rdata, g_err);
        end
        do_req(1'b0, 1'b0, SZ_HALF, 1'b0, 32'h102, 32'h0, g_rdata, g_err, g_lat);
        tests_run++;
        if (g_rdata !== 32'hFFFF_8001 || g_err !== 2'b00) begin
            tests_failed++;
            $display("FAIL lh: rdata=%h err=%b required ffff8001/00", g_rdata, g_err);
        end
    endtask

    task automatic test_store_byte();
        ack_delay = 0;
        mem_arr[8'h80] = 32'h1122_3344; ref_mem[8'h80] = 32'h1122_5A44;
        do_req(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h201, 32'hABCD_EF5A, g_rdata, g_err, g_lat);
        tests_run++;
        if (wr_cnt != 1 || last_addr !== 32'h200) begin
            tests_failed++;
            $display("FAIL sb_write: writes=%0d addr=%h required 1/00000200", wr_cnt, last_addr);
        end
        tests_run++;
        if (mem_arr[8'h80] !== 32'h1122_5A44 || g_err !== 2'b00 || g_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL sb_result: mem=%h err=%b rdata=%h required 11225a44/00/0", mem_arr[8'h80], g_err, g_rdata);
        end
`ifdef SUBWORD_MEM_BE_EN
        tests_run++;
        if (rd_cnt != 0 || last_be !== 4'b0010 || last_wdata !== 32'h5A5A_5A5A) begin
            tests_failed++;
            $display("FAIL sb_be: reads=%0d be=%b wdata=%h required 0/0010/5a5a5a5a", rd_cnt, last_be, last_wdata);
        end
        tests_run++;
        if (g_lat != 2) begin
            tests_failed++;
            $display("FAIL sb_latency: %0d cycles required 2", g_lat);
        end
`else
        tests_run++;
        if (rd_cnt != 1 || last_wdata !== 32'h1122_5A44) begin
            tests_failed++;
            $display("FAIL sb_rmw: reads=%0d wdata=%h required 1/11225a44", rd_cnt, last_wdata);
        end
        tests_run++;
        if (g_lat != 3) begin
            tests_failed++;
            $display("FAIL sb_latency: %0d cycles required 3", g_lat);
        end
`endif
    endtask

    task automatic test_errors();
        logic [1:0]  e_sz  [3] = '{SZ_WORD, SZ_HALF, SZ_ILLEGAL};
        logic [31:0] e_adr [3] = '{32'h102, 32'h105, 32'h100};
        bit          e_st  [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  e_err [3] = '{2'b01, 2'b01, 2'b11};
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, e_st[i], e_sz[i], 1'b0, e_adr[i], 32'hFFFF_FFFF, g_rdata, g_err, g_lat);
            tests_run++;
            if (g_err !== e_err[i] || g_rdata !== 32'h0) begin
                tests_failed++;
                $display("FAIL err_code[%0d]: err=%b rdata=%h required %b/0", i, g_err, g_rdata, e_err[i]);
            end
            tests_run++;
            if (g_lat != 1) begin
                tests_failed++;
                $display("FAIL err_latency[%0d]: %0d cycles required 1", i, g_lat);
            end
            tests_run++;
            if (req_cycles != 0) begin
                tests_failed++;
                $display("FAIL err_no_mem[%0d]: mem_req cycles=%0d required 0", i, req_cycles);
            end
        end
    endtask

    task automatic test_timeout();
        no_ack = 1'b1;
        do_req(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, g_rdata, g_err, g_lat);
        tests_run++;
        if (g_err !== 2'b10 || g_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL to_load_err: err=%b rdata=%h required 10/0", g_err, g_rdata);
        end
        tests_run++;
        if (req_cycles != TO || g_lat != TO + 1) begin
            tests_failed++;
            $display("FAIL to_load_cycles: req_cycles=%0d lat=%0d required %0d/%0d", req_cycles, g_lat, TO, TO + 1);
        end
        tests_run++;
        if (mbus.mem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL to_req_drop: mem_req=%b required 0", mbus.mem_req);
        end
        mem_arr[8'h80] = 32'hCAFE_F00D; ref_mem[8'h80] = 32'hCAFE_F00D;
        do_req(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h201, 32'h77, g_rdata, g_err, g_lat);
        tests_run++;
        if (g_err !== 2'b10 || req_cycles != TO || g_lat != TO + 1) begin
            tests_failed++;
            $display("FAIL to_sb: err=%b req_cycles=%0d lat=%0d required 10/%0d/%0d", g_err, req_cycles, g_lat, TO, TO + 1);
        end
`ifndef SUBWORD_MEM_BE_EN
        tests_run++;
        if (we_cycles != 0) begin
            tests_failed++;
            $display("FAIL to_sb_no_write: mem_we cycles=%0d required 0", we_cycles);
        end
`endif
        tests_run++;
        if (mem_arr[8'h80] !== 32'hCAFE_F00D) begin
            tests_failed++;
            $display("FAIL to_sb_mem: mem=%h required cafef00d", mem_arr[8'h80]);
        end
        no_ack = 1'b0;
    endtask

    task automatic test_reset_mid_wr();
        int n;
        no_ack = 1'b1;
        @(negedge clk);
        cpu.req_valid = 1'b1; cpu.req_store = 1'b1; cpu.req_size = SZ_WORD;
        cpu.req_unsigned = 1'b0; cpu.req_addr = 32'h300; cpu.req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        cpu.req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (mbus.mem_we !== 1'b1 && n < 10);
        tests_run++;
        if (mbus.mem_we !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_wr_reach: mem_we=%b required 1", mbus.mem_we);
        end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (mbus.mem_req !== 1'b0 || mbus.mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset_mem: req=%b we=%b required 0/0", mbus.mem_req, mbus.mem_we);
        end
        tests_run++;
        if (cpu.req_ready !== 1'b1 || cpu.resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset_ready: ready=%b valid=%b required 1/0", cpu.req_ready, cpu.resp_valid);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        no_ack = 1'b0;
        ack_delay = 0;
        mem_arr[8'hC0] = 32'h0BAD_F00D; ref_mem[8'hC0] = 32'h0BAD_F00D;
        do_req(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h300, 32'h0, g_rdata, g_err, g_lat);
        tests_run++;
        if (g_rdata !== 32'h0BAD_F00D || g_err !== 2'b00 || g_lat != 2) begin
            tests_failed++;
            $display("FAIL post_reset_lw: rdata=%h err=%b lat=%0d required 0badf00d/00/2", g_rdata, g_err, g_lat);
        end
    endtask

    task automatic test_random(input int count, input bit b2b);
        bit st, uns;
        logic [1:0] sz, e_err;
        logic [31:0] a, wd, e_rdata;
        int d, e_lat, e_rd, e_wr;
        logic [7:0] idx;
        for (int i = 0; i < count; i++) begin
            st  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a   = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0)
                a = (sz == 2'b10) ? (a & ~32'h3) : (sz == 2'b01) ? (a & ~32'h1) : a;
            wd  = $urandom;
            d   = b2b ? 0 : $urandom_range(0, 2);
            ack_delay = d;
            idx = a[9:2];
            e_err = model_err(sz, a);
            e_rdata = 32'h0;
            if (e_err != 2'b00) begin
                e_lat = 1; e_rd = 0; e_wr = 0;
            end else if (!st) begin
                e_rdata = model_load(ref_mem[idx], sz, uns, a);
                e_lat = 2 + d; e_rd = 1; e_wr = 0;
            end else begin
                ref_mem[idx] = model_store(ref_mem[idx], sz, wd, a);
`ifdef SUBWORD_MEM_BE_EN
                e_lat = 2 + d; e_rd = 0; e_wr = 1;
`else
                if (sz == 2'b10) begin e_lat = 2 + d; e_rd = 0; e_wr = 1; end
                else begin e_lat = 3 + 2 * d; e_rd = 1; e_wr = 1; end
`endif
            end
            do_req(b2b && i > 0, st, sz, uns, a, wd, g_rdata, g_err, g_lat);
            tests_run++;
            if (g_err !== e_err || g_rdata !== e_rdata) begin
                tests_failed++;
                $display("FAIL rand_resp[%0d]: err=%b rdata=%h required %b/%h (st=%0d sz=%0d a=%h)",
                         i, g_err, g_rdata, e_err, e_rdata, st, sz, a);
            end
            tests_run++;
            if (g_lat != e_lat || rd_cnt != e_rd || wr_cnt != e_wr) begin
                tests_failed++;
                $display("FAIL rand_timing[%0d]: lat=%0d rd=%0d wr=%0d required %0d/%0d/%0d",
                         i, g_lat, rd_cnt, wr_cnt, e_lat, e_rd, e_wr);
            end
            tests_run++;
            if (mem_arr[idx] !== ref_mem[idx]) begin
                tests_failed++;
                $display("FAIL rand_mem[%0d]: word=%h required %h", i, mem_arr[idx], ref_mem[idx]);
            end
            if (e_rd + e_wr > 0) begin
                tests_run++;
                if (last_addr !== {a[31:2], 2'b00}) begin
                    tests_failed++;
                    $display("FAIL rand_addr[%0d]: mem_addr=%h required %h", i, last_addr, {a[31:2], 2'b00});
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu.req_valid = 1'b0; cpu.req_store = 1'b0; cpu.req_size = 2'b00;
        cpu.req_unsigned = 1'b0; cpu.req_addr = 32'h0; cpu.req_wdata = 32'h0;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = $urandom;
            ref_mem[i] = mem_arr[i];
        end
        test_reset();
        test_loads();
        test_store_byte();
        test_errors();
        test_timeout();
        test_reset_mid_wr();
        test_random(40, 1'b0);
        test_random(8, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/subword_mem_ctrl.md
Name: subword_mem_ctrl

Overview:
- Sequences byte, halfword and word loads and stores between the execute stage and a single-port, word-addressed data memory.
- Extracts and sign/zero-extends sub-word load data.
- Performs sub-word stores as read-modify-write, or as a direct byte-enabled write when the optional feature is compiled in.
- Detects misaligned and illegal-size requests and memory timeouts, and reports them with an error code.

Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT_CYCLES, 255, maximum wait for mem_ack in one memory phase; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  zero-extend load data (LBU/LHU).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; the low bytes are used for sub-word stores.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal size.
- mem_req  out  1  memory access request, level-held.
- mem_we  out  1  write strobe, qualified by mem_req.
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits = 0.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid with mem_ack on a read.
- mem_ack  in  1  access complete.

Behaviour:
- Reset: async clear, effective immediately, including mid-operation.
  - All outputs 0, except req_ready = 1.
  - FSM goes to IDLE and the timeout counter clears.
  - mem_req drops without waiting for mem_ack.
- FSM states: IDLE, RD, WR, RESP.
- Handshake: req_ready = 1 only in IDLE. The request is accepted on req_valid && req_ready, and all request fields are latched at acceptance.
- Transitions from IDLE on acceptance:
  - error check fails -> RESP;
  - load -> RD;
  - word store -> WR;
  - sub-word store -> RD (RMW), or WR when the optional feature is compiled in.
- Transitions from RD and WR:
  - RD on mem_ack: load -> RESP; RMW store -> WR, capturing mem_rdata merged with the store lanes.
  - WR on mem_ack -> RESP.
  - RESP -> IDLE unconditionally, after exactly one cycle. There is no response backpressure.
- Memory signals:
  - mem_req is high for every cycle in RD and WR; mem_we = 1 only in WR.
  - mem_addr = {addr[ADDR_W-1:2], 2'b00} for the whole operation.
  - mem_ack outside RD or WR is ignored.
- Error checks, in priority order. A request that fails any check causes no memory access.
  - size 11 -> err 11.
  - Half with addr[0] = 1 -> err 01.
  - Word with addr[1:0] != 0 -> err 01.
- Lane selection:
  - Byte lane = addr[1:0].
  - Half lane = addr[1].
  - Load data = the selected lane shifted to bit 0, then sign-extended (req_unsigned = 0) or zero-extended (req_unsigned = 1).
  - Word loads are passed through unchanged.
- RMW merge: replace only the selected lane(s) of the read word with wdata[7:0] or wdata[15:0]; all other bytes are unchanged.
- Timeout:
  - The counter clears on entry to RD or WR and increments every cycle without mem_ack.
  - When count reaches TIMEOUT_CYCLES with no ack: drop mem_req, go to RESP with err 10.
  - On a timeout in the RD phase of an RMW, no write is issued.
- Latency (request accepted in cycle T):
  - Error: resp_valid at T+1.
  - Load with same-cycle ack: resp_valid at T+2.
  - RMW store with same-cycle acks: resp_valid at T+3.
- resp_rdata and resp_err are valid only while resp_valid = 1 and are 0 otherwise.

Optional Feature:
- SUBWORD_MEM_BE_EN defined:
  - Adds output mem_be (4 bits): one bit per byte lane, all ones for word writes, 0 on reads.
  - Sub-word stores go IDLE -> WR directly, with store data replicated across lanes: byte to all 4 lanes, half to both halves.
  - Store latency matches word stores.
- Not defined:
  - No mem_be port.
  - Sub-word stores use read-modify-write as above.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - error codes ERR_OK, ERR_MISALIGN, ERR_TIMEOUT, ERR_SIZE;
  - the FSM state enum.
- One combinational sub-module, subword_lane_unit. It performs lane extraction with extension, the RMW merge, and lane-enable generation. The FSM and timeout counter stay in the top module.

Test Plan:
- LB, addr 0x103, mem_rdata 0x80AABBCC, ack on first cycle -> resp_rdata 0xFFFFFF80, err 00, resp_valid 2 cycles after acceptance.
- LHU, addr 0x102, mem_rdata 0x8001FFFF -> resp_rdata 0x00008001; LH at the same address -> 0xFFFF8001.
- SB, addr 0x201, wdata 0x5A, RMW read returns 0x11223344 -> one write with mem_wdata 0x11225A44, mem_addr 0x200, resp at T+3.
  - With SUBWORD_MEM_BE_EN: no read, mem_be 0010, mem_wdata 0x5A5A5A5A.
- Misaligned and illegal requests, none touching memory (mem_req stays 0):
  - LW at 0x102 -> err 01, resp at T+1.
  - SH at 0x105 -> err 01, resp at T+1.
  - size 11 -> err 11, resp at T+1.
- TIMEOUT_CYCLES = 4, mem_ack held low -> mem_req high 4 cycles then drops, err 10.
  - SB with timeout in the read phase -> mem_we never asserts.
- rst_n low mid-WR -> mem_req/mem_we drop asynchronously, req_ready = 1.
  - A new LW issued after reset completes normally.
